seq_restoring_divider7: RTL and testbench
=========================================

Name: seq_restoring_divider7

Overview:
- Multi-cycle unsigned restoring divider. It is the inverse arithmetic direction of the team's 7-bit look-ahead adder block.
- Computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock, using a repeated trial subtraction.
- Sits beside the ALU datapath and is driven by the control unit with a start/busy/done handshake.
- Lets the CPU implement DIV/MOD without a large combinational array.

Parameters:
- WIDTH, 7, operand/result width in bits (must be >= 2).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a division; sampled only when busy=0.
- dividend  in  WIDTH  numerator; captured on the accepting edge.
- divisor  in  WIDTH  denominator; captured on the accepting edge.
- busy  out  1  high while iterating (RUN state).
- done  out  1  single-cycle pulse; results valid from this cycle.
- quotient  out  WIDTH  registered quotient, held until the next accepted start.
- remainder  out  WIDTH  registered remainder, held likewise.
- div_by_zero  out  1  registered flag for the last accepted operation.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset (rst_n=0, any time): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal shift regs and counter cleared.
  - Reset mid-RUN aborts the operation; no done is produced.
  - Operation resumes on the first clk edge after rst_n rises.
- States:
  - IDLE (busy=0, done=0).
  - RUN (busy=1, done=0).
  - DONE (busy=0, done=1, lasts exactly one cycle).
- Acceptance: start=1 at a rising edge while in IDLE or DONE.
  - Back-to-back operation is allowed: start in the DONE cycle is accepted.
  - start while in RUN is ignored and is not queued.
- Normal operation (divisor != 0), start sampled at end of cycle 0:
  - Accepting edge: rem_acc <= 0, quo_acc <= dividend, div_r <= divisor, count <= WIDTH, state <= RUN.
  - Each RUN edge:
    - Form {rem_acc,quo_acc} shifted left by 1 (WIDTH+1-bit partial remainder).
    - trial = partial - {1'b0,div_r}, computed in WIDTH+1 bits with borrow out.
    - If no borrow: rem_acc <= trial[WIDTH-1:0] and quo_acc LSB <= 1.
    - Otherwise: rem_acc <= partial[WIDTH-1:0] and quo_acc LSB <= 0.
    - count decrements.
  - busy is high in cycles 1..WIDTH.
  - On the edge where count reaches 0: state <= DONE; quotient <= final quo_acc; remainder <= final rem_acc; div_by_zero <= 0.
  - done is high in cycle WIDTH+1. Latency from start to done = WIDTH+1 cycles (8 for the default).
- Divide by zero (divisor == 0 at acceptance):
  - No RUN phase. The accepting edge goes directly to DONE.
  - quotient <= all ones, remainder <= dividend, div_by_zero <= 1.
  - done is high in cycle 1; busy stays 0.
- Outputs quotient, remainder and div_by_zero change only on entry to DONE (or on reset). They are stable throughout RUN and IDLE.
- dividend and divisor may change freely after the accepting edge.
- Edge cases:
  - dividend=0 gives q=0, r=0 after the full WIDTH cycles.
  - divisor > dividend gives q=0, r=dividend.
  - Maximum values must not overflow; the WIDTH+1-bit trial width guarantees this.

Decomposition:
- Shared package (alu_pkg):
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default DIV_WIDTH=7.
  - Counter width = $clog2(WIDTH+1).
- One combinational sub-module, div_trial_sub: WIDTH+1-bit subtractor returning difference and borrow_out, implemented as A + ~B + 1 with look-ahead carry.
- Top module holds the FSM, counter, shift registers and result registers.

Test Plan:
- Reset, then start with 100/7 in cycle 0 -> busy high cycles 1-7; done high only in cycle 8; quotient=14, remainder=2, div_by_zero=0.
- 127/1 -> quotient=127, remainder=0. 5/9 -> quotient=0, remainder=5. 0/3 -> quotient=0, remainder=0. Each reports done at cycle 8.
- 45/0 -> done in cycle 1, busy never high; quotient=127, remainder=45, div_by_zero=1. A following 45/5 -> quotient=9, remainder=0, div_by_zero=0.
- Start 100/7, then pulse start with 20/3 in cycle 3 -> ignored; results 14/2 at cycle 8. Then start 20/3 in the done cycle (8) -> done in cycle 16 with quotient=6, remainder=2.
- Start 100/7, assert rst_n=0 asynchronously mid-cycle 4 -> all outputs 0 immediately, no done pulse. After release, 60/4 -> quotient=15, remainder=0 with normal 8-cycle latency.
- Randomised 1000 operand pairs (divisor including 0) against a reference model -> dividend = quotient*divisor + remainder and remainder < divisor; when divisor=0 the flag and saturated outputs are checked.

Source files
------------

// File: rtl/seq_restoring_divider7_pkg.sv
// Shared ALU definitions: divider state encoding and sizing helpers.
// Used by the divider, its interface and the bench.
package alu_pkg;

  localparam int DIV_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider7_if.sv
// Control-unit to divider handshake and operand/result bundle.
// The control unit drives start and operands; the divider returns status and results.
interface seq_restoring_divider7_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_restoring_divider7_trial_sub.sv
// Trial subtractor: A + ~B + 1 with generate/propagate carry,
// borrow is the inverted carry out.
module div_trial_sub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  always_comb begin
    g    = a_i & ~b_i;
    p    = a_i ^ ~b_i;
    c    = '0;
    c[0] = 1'b1;
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign diff_o   = p ^ c[W-1:0];
  assign borrow_o = ~c[W];

endmodule

// File: rtl/seq_restoring_divider7.sv
// Sequential restoring divider: one quotient bit per clock,
// divide-by-zero short-circuits straight to DONE.
module seq_restoring_divider7
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_restoring_divider7_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic [WIDTH-1:0] rout_q, rout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             unused_trial_msb;

  assign partial = {rem_q, quo_q[WIDTH-1]};

  div_trial_sub #(
    .W (WIDTH + 1)
  ) u_sub (
    .a_i      (partial),
    .b_i      ({1'b0, div_q}),
    .diff_o   (trial),
    .borrow_o (borrow)
  );

  // Without a borrow the difference fits in WIDTH bits.
  assign unused_trial_msb = trial[WIDTH];

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    qout_d  = qout_q;
    rout_d  = rout_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          if (bus.divisor == '0) begin
            state_d = DONE;
            qout_d  = '1;
            rout_d  = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            rem_d   = '0;
            quo_d   = bus.dividend;
            div_d   = bus.divisor;
            cnt_d   = CW'(WIDTH);
          end
        end
      end
      RUN: begin
        rem_d = borrow ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          qout_d  = quo_d;
          rout_d  = rem_d;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      qout_q  <= '0;
      rout_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      qout_q  <= qout_d;
      rout_q  <= rout_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = qout_q;
  assign bus.remainder   = rout_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider7.sv
// Scoreboard bench for the restoring divider: stimulus pushes expected
// results and done cycle, a negedge monitor pops and compares on done.
module tb_seq_restoring_divider7;
  import alu_pkg::*;

  localparam int W = 7;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           cyc;
    int           nbusy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_restoring_divider7_if #(.WIDTH(W)) bus ();

  seq_restoring_divider7 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  exp_t me;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   n_pass = 0;
  int   n_tot = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      sb.delete();
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_tot++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          me = sb.pop_front();
          chk("quotient", 32'(bus.quotient), 32'(me.q));
          chk("remainder", 32'(bus.remainder), 32'(me.r));
          chk("div_by_zero", 32'(bus.div_by_zero), 32'(me.dbz));
          chk("done_cycle", cyc, me.cyc);
          chk("busy_cycles", busy_cnt, me.nbusy);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input int a, input int b);
    exp_t e;
    bus.dividend = a[W-1:0];
    bus.divisor  = b[W-1:0];
    bus.start    = 1'b1;
    e.q     = (b == 0) ? 7'h7f : 7'(a / b);
    e.r     = (b == 0) ? 7'(a) : 7'(a % b);
    e.dbz   = (b == 0);
    e.cyc   = cyc + ((b == 0) ? 1 : W + 1);
    e.nbusy = (b == 0) ? 0 : W;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 7'h55;
    bus.divisor  = 7'h2a;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (sb.size() != 0) begin
      n_tot++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int a;
    int b;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #3;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_q", 32'(bus.quotient), 0);
    chk("rst_r", 32'(bus.remainder), 0);
    chk("rst_dbz", 32'(bus.div_by_zero), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1);

    issue(100, 7); wait_drain();
    issue(127, 1); wait_drain();
    issue(5, 9);   wait_drain();
    issue(0, 3);   wait_drain();
    issue(127, 127); wait_drain();
    issue(45, 0);  wait_drain();
    issue(45, 5);  wait_drain();

    c0 = cyc;
    issue(100, 7);
    step(2);
    bus.start    = 1'b1;
    bus.dividend = 7'd20;
    bus.divisor  = 7'd3;
    step(1);
    bus.start = 1'b0;
    chk("hold_q_run", 32'(bus.quotient), 9);
    chk("busy_mid_run", 32'(bus.busy), 1);
    step(4);
    chk("b2b_at_done", cyc, c0 + 8);
    issue(20, 3);
    wait_drain();

    c0 = cyc;
    issue(100, 7);
    step(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q", 32'(bus.quotient), 0);
    chk("arst_r", 32'(bus.remainder), 0);
    chk("arst_dbz", 32'(bus.div_by_zero), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_done", 32'(bus.done), 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(6);
    issue(60, 4);
    wait_drain();

    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, 127);
      b = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 127);
      issue(a, b);
      wait_drain();
    end

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
